// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the accumulator-pipeline hazard controller:
// action encodings, parameter defaults and accumulator mask positions.
package pipeline_ctrl_pkg;

  localparam int NUM_ACUM_DEF  = 2;
  localparam int CNT_WIDTH_DEF = 16;

  // Bit positions inside the source/destination accumulator masks.
  localparam int ACUM_A = 0;
  localparam int ACUM_B = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_RAW   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_MEMW  = 2'd3
  } action_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-deep shift register of destination masks for the EX, MEM and WB
// stages; reports every accumulator with a write still in flight.
module hazard_scoreboard #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  input  logic [W-1:0] din,
  output logic [W-1:0] inflight
);

  logic [W-1:0] sb [3];

  // NOTE: this array is three flops wide, not a RAM, so resetting it is cheap
  // and required: a reset must discard every pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sb[i] <= '0;
    end else if (advance) begin
      sb[0] <= din;
      sb[1] <= sb[0];
      sb[2] <= sb[1];
    end
  end

  assign inflight = sb[0] | sb[1] | sb[2];

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage accumulator pipeline: picks
// one action per cycle (MEMW > FLUSH > RAW > RUN) and keeps stall statistics.
module hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NUM_ACUM  = NUM_ACUM_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iValid_ID,
  input  logic [NUM_ACUM-1:0]  iSrcAcum_ID,
  input  logic [NUM_ACUM-1:0]  iDstAcum_ID,
  input  logic                 iBrTaken_EX,
  input  logic                 iMemBusy,
  output logic                 oEnPC,
  output logic                 oEnIF_ID,
  output logic                 oFlushIF_ID,
  output logic                 oBubbleID_EX,
  output logic                 oEnID_EX,
  output logic                 oEnEX_MEM,
  output logic                 oEnMEM_WB,
  output logic [1:0]           oState,
  output logic [CNT_WIDTH-1:0] oStallCnt,
  output logic [CNT_WIDTH-1:0] oFlushCnt
);

  logic [NUM_ACUM-1:0]  inflight;
  logic [NUM_ACUM-1:0]  sb_din;
  logic                 raw;
  logic                 advance;
  action_e              action;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  hazard_scoreboard #(.W(NUM_ACUM)) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .advance  (advance),
    .din      (sb_din),
    .inflight (inflight)
  );

  assign raw = iValid_ID & (|(iSrcAcum_ID & inflight));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    action = ST_RUN;
    if (iMemBusy)         action = ST_MEMW;
    else if (iBrTaken_EX) action = ST_FLUSH;
    else if (raw)         action = ST_RAW;
  end

  // Only a real instruction issuing from ID in a RUN cycle enters EX.
  assign advance = (action != ST_MEMW);
  assign sb_din  = (action == ST_RUN && iValid_ID) ? iDstAcum_ID : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (action == ST_RAW && stall_cnt != '1)   stall_cnt <= stall_cnt + 1'b1;
      if (action == ST_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    oEnPC        = 1'b0;
    oEnIF_ID     = 1'b0;
    oFlushIF_ID  = 1'b0;
    oBubbleID_EX = 1'b0;
    oEnID_EX     = 1'b0;
    oEnEX_MEM    = 1'b0;
    oEnMEM_WB    = 1'b0;
    if (!reset) begin
      unique case (action)
        ST_RUN: begin
          oEnPC     = 1'b1;
          oEnIF_ID  = 1'b1;
          oEnID_EX  = 1'b1;
          oEnEX_MEM = 1'b1;
          oEnMEM_WB = 1'b1;
        end
        ST_RAW: begin
          oBubbleID_EX = 1'b1;
          oEnID_EX     = 1'b1;
          oEnEX_MEM    = 1'b1;
          oEnMEM_WB    = 1'b1;
        end
        ST_FLUSH: begin
          oEnPC        = 1'b1;
          oEnIF_ID     = 1'b1;
          oFlushIF_ID  = 1'b1;
          oBubbleID_EX = 1'b1;
          oEnID_EX     = 1'b1;
          oEnEX_MEM    = 1'b1;
          oEnMEM_WB    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign oState    = reset ? ST_RUN : action;
  assign oStallCnt = reset ? '0 : stall_cnt;
  assign oFlushCnt = reset ? '0 : flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the 5-stage accumulator pipeline (IF, ID, EX, MEM, WB). It drives the enable, flush and bubble controls of the PC and the four `regN` pipeline registers.
- RAW hazards on accumulators A/B are resolved by stalling, with no forwarding.
- A branch taken in EX squashes the wrong-path IF/ID instructions.
- The whole pipeline freezes while the data memory reports busy.
- An internal scoreboard tracks in-flight accumulator writes; saturating counters expose stall and flush statistics.

## Interface
- `NUM_ACUM`, 2: number of accumulators; bit0 = A, bit1 = B.
- `CNT_WIDTH`, 16: width of the statistics counters.

- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `iValid_ID` in 1: ID holds a real instruction (not a bubble).
- `iSrcAcum_ID` in `NUM_ACUM`: accumulators read by the ID instruction.
- `iDstAcum_ID` in `NUM_ACUM`: accumulators written by the ID instruction.
- `iBrTaken_EX` in 1: branch resolved taken in EX this cycle.
- `iMemBusy` in 1: data memory not ready; freeze request.
- `oEnPC` out 1: PC update enable.
- `oEnIF_ID` out 1: IF/ID register enable.
- `oFlushIF_ID` out 1: load zero (NOP) into IF/ID.
- `oBubbleID_EX` out 1: load zero (NOP) into ID/EX instead of ID outputs.
- `oEnID_EX`, `oEnEX_MEM`, `oEnMEM_WB` out 1 each: register enables.
- `oState` out 2: current cycle action; 0 RUN, 1 RAW, 2 FLUSH, 3 MEMW.
- `oStallCnt` out `CNT_WIDTH`: RAW stall cycles, saturating.
- `oFlushCnt` out `CNT_WIDTH`: taken branches flushed, saturating.

## Operation
- **Scoreboard.** `sb[0..2]` holds destination masks for the EX, MEM and WB stages. Accumulators are written at the clock edge that ends WB, so a producer in any of EX/MEM/WB is a hazard.
- **Hazard term.** `raw = iValid_ID & |(iSrcAcum_ID & (sb[0]|sb[1]|sb[2]))`.
- **Action priority:** MEMW > FLUSH > RAW > RUN.
  - **MEMW** (`iMemBusy=1`): all enables 0, flush 0, bubble 0; scoreboard and counters hold.
  - **FLUSH** (`iBrTaken_EX=1`):
    - `oEnPC=1` (loads branch target), `oFlushIF_ID=1`, `oBubbleID_EX=1`.
    - All other enables 1.
    - `sb[0]` shifts in 0.
    - `oFlushCnt` increments.
    - FLUSH overrides a simultaneous `raw`.
  - **RAW**:
    - `oEnPC=0`, `oEnIF_ID=0`, `oBubbleID_EX=1`.
    - `oEnID_EX`, `oEnEX_MEM`, `oEnMEM_WB` = 1.
    - `sb[0]` shifts in 0.
    - `oStallCnt` increments.
  - **RUN**: all enables 1, flush/bubble 0; `sb[0]` shifts in `iValid_ID ? iDstAcum_ID : 0`.
- **Shift.** On every non-MEMW cycle: `sb[2]<=sb[1]`, `sb[1]<=sb[0]`.
- **Stall bound.** A RAW stall lasts at most 3 consecutive cycles. Exceeding that is an error; the bench asserts it.
- **Counters.** Saturate at all-ones and never wrap.

## Timing
- All control outputs and `oState` are combinational from the inputs and the scoreboard. They act on the same clock edge.
- The scoreboard and counters update on `posedge clk`.
- While `reset=1`, all outputs are 0, regardless of other inputs.
- On the reset edge: scoreboard cleared, counters cleared.
- First cycle after reset deasserts: RUN, with no hazard possible.
- Reset asserted mid-stall or mid-freeze takes effect at the next edge and discards all pending scoreboard entries.
- `iMemBusy` together with `iBrTaken_EX`: MEMW wins. The branch stays visible in the frozen EX stage and is flushed on the first non-busy cycle.
- Counter at saturation plus an increment event: the value holds.

## Structure
- `pipeline_ctrl_pkg` holds:
  - the `oState` encodings (RUN/RAW/FLUSH/MEMW);
  - the `NUM_ACUM` and `CNT_WIDTH` defaults;
  - the accumulator mask bit positions (A=0, B=1).
- One sub-module, `hazard_scoreboard`:
  - 3-deep shift register of masks with `advance` and `din` inputs;
  - returns the OR of all entries.
- The top level holds the priority logic and the two saturating counters.

## Test plan
- **Back-to-back RAW.** Write A (`dst=01`) followed by an instruction with `src=01` → RAW for exactly 3 cycles, `oBubbleID_EX=1`, `oEnPC=0`, then RUN. `oStallCnt=3`.
- **Independent pair.** Write A, then read B (`src=10`) → no stall; `oState=0` throughout.
- **Taken branch.** `iBrTaken_EX=1` for 1 cycle → `oFlushIF_ID=1`, `oBubbleID_EX=1`, `oEnPC=1`, `oFlushCnt=1`. The wrong-path destination is never entered into `sb`.
- **Branch during RAW stall.** → FLUSH wins, stall aborted, `oStallCnt` not incremented that cycle.
- **Freeze.** `iMemBusy=1` for 4 cycles mid-hazard → all enables 0, scoreboard frozen. The remaining stall cycles resume afterward.
- **Saturation and reset.** Preload `oStallCnt` to `0xFFFF` by forcing long sequences → it holds at `0xFFFF`. Assert `reset` mid-stall → next cycle all counters 0, `oState=0`.
